// File: rtl/branch_sequencer_if.sv
// Handshake and control-strobe bundle between the branch sequencer and its datapath.
// The master side drives start/ready/IR/bus and observes the strobes.
interface branch_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] bus_data;

  logic                  pc_out;
  logic                  mar_in;
  logic                  inc_pc;
  logic                  z_in;
  logic                  zlow_out;
  logic                  pc_in;
  logic                  read;
  logic                  mdr_in;
  logic                  mdr_out;
  logic                  ir_in;
  logic                  grb;
  logic                  rout;
  logic                  y_in;
  logic                  c_out;
  logic [4:0]            alu_op;
  logic                  con_ff;
  logic                  busy;
  logic                  done;
  logic                  illegal;

  modport master (
    output start, mem_ready, ir, bus_data,
    input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
           mdr_out, ir_in, grb, rout, y_in, c_out, alu_op, con_ff, busy,
           done, illegal
  );

  modport slave (
    input  start, mem_ready, ir, bus_data,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
           mdr_out, ir_in, grb, rout, y_in, c_out, alu_op, con_ff, busy,
           done, illegal
  );
endinterface

// File: rtl/branch_sequencer.sv
// Fetch + conditional-branch control sequencer. Strobes are a pure decode of the
// state register, con_ff and mem_ready; ir/bus_data only feed registers and next-state.
module branch_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [4:0]  BR_OPCODE      = 5'b10010,
  parameter int unsigned COND_LSB       = 19,
  parameter bit          SKIP_NOT_TAKEN = 1'b1,
  parameter logic [4:0]  ALU_ADD        = 5'b00011
) (
  input logic                clk,
  input logic                clr,
  branch_sequencer_if.slave  bus
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  logic [3:0] state_q, state_d;
  logic       con_ff_q, con_ff_d;
  logic       illegal_q, illegal_d;
  logic       op_ok_q, op_ok_d;

  logic [4:0] opcode;
  logic [1:0] c2;
  logic       cond;

  assign opcode = bus.ir[DATA_WIDTH-1 -: 5];
  assign c2     = bus.ir[COND_LSB+1 : COND_LSB];

  always_comb begin
    cond = 1'b0;
    case (c2)
      2'b00:   cond = (bus.bus_data == '0);
      2'b01:   cond = (bus.bus_data != '0);
      2'b10:   cond = ~bus.bus_data[DATA_WIDTH-1];
      default: cond = bus.bus_data[DATA_WIDTH-1];
    endcase
  end

  // The IR is expected to be settled by T2; the opcode check is registered there
  // so that the T3 grb/rout decode never sees ir combinationally.
  always_comb begin
    state_d   = state_q;
    con_ff_d  = con_ff_q;
    illegal_d = illegal_q;
    op_ok_d   = op_ok_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
        end
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        if (bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        state_d = S_T3;
        op_ok_d = (opcode == BR_OPCODE);
      end
      S_T3: begin
        if (!op_ok_q) begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          con_ff_d = cond;
          if (SKIP_NOT_TAKEN && !cond) state_d = S_DONE;
          else                         state_d = S_T4;
        end
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      con_ff_q  <= 1'b0;
      illegal_q <= 1'b0;
      op_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      con_ff_q  <= con_ff_d;
      illegal_q <= illegal_d;
      op_ok_q   <= op_ok_d;
    end
  end

  logic pc_out_s, mar_in_s, inc_pc_s, z_in_s, zlow_out_s, pc_in_s, read_s;
  logic mdr_in_s, mdr_out_s, ir_in_s, grb_s, rout_s, y_in_s, c_out_s;
  logic [4:0] alu_op_s;

  always_comb begin
    pc_out_s   = 1'b0;
    mar_in_s   = 1'b0;
    inc_pc_s   = 1'b0;
    z_in_s     = 1'b0;
    zlow_out_s = 1'b0;
    pc_in_s    = 1'b0;
    read_s     = 1'b0;
    mdr_in_s   = 1'b0;
    mdr_out_s  = 1'b0;
    ir_in_s    = 1'b0;
    grb_s      = 1'b0;
    rout_s     = 1'b0;
    y_in_s     = 1'b0;
    c_out_s    = 1'b0;
    alu_op_s   = 5'd0;
    case (state_q)
      S_T0: begin
        pc_out_s = 1'b1;
        mar_in_s = 1'b1;
        inc_pc_s = 1'b1;
        z_in_s   = 1'b1;
      end
      S_T1: begin
        // PC is reloaded only on the cycle the read completes.
        zlow_out_s = 1'b1;
        read_s     = 1'b1;
        mdr_in_s   = 1'b1;
        pc_in_s    = bus.mem_ready;
      end
      S_T2: begin
        mdr_out_s = 1'b1;
        ir_in_s   = 1'b1;
      end
      S_T3: begin
        grb_s  = op_ok_q;
        rout_s = op_ok_q;
      end
      S_T4: begin
        pc_out_s = 1'b1;
        y_in_s   = 1'b1;
      end
      S_T5: begin
        c_out_s  = 1'b1;
        z_in_s   = 1'b1;
        alu_op_s = ALU_ADD;
      end
      S_T6: begin
        zlow_out_s = 1'b1;
        pc_in_s    = con_ff_q;
      end
      default: ;
    endcase
  end

  assign bus.pc_out   = pc_out_s;
  assign bus.mar_in   = mar_in_s;
  assign bus.inc_pc   = inc_pc_s;
  assign bus.z_in     = z_in_s;
  assign bus.zlow_out = zlow_out_s;
  assign bus.pc_in    = pc_in_s;
  assign bus.read     = read_s;
  assign bus.mdr_in   = mdr_in_s;
  assign bus.mdr_out  = mdr_out_s;
  assign bus.ir_in    = ir_in_s;
  assign bus.grb      = grb_s;
  assign bus.rout     = rout_s;
  assign bus.y_in     = y_in_s;
  assign bus.c_out    = c_out_s;
  assign bus.alu_op   = alu_op_s;
  assign bus.con_ff   = con_ff_q;
  assign bus.illegal  = illegal_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench: two sequencers (skip / no-skip on not-taken) share stimulus;
// each run pushes expected per-run summaries that a negedge monitor checks at done.
module tb_branch_sequencer;
  localparam int DW = 32;
  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [31:0] IR_MI  = 32'h9318_0019;
  localparam logic [31:0] IR_ZR  = 32'h9300_0019;
  localparam logic [31:0] IR_NZ  = 32'h9308_0019;
  localparam logic [31:0] IR_PL  = 32'h9310_0019;
  localparam logic [31:0] IR_BAD = 32'h0000_0000;

  logic clk = 1'b0;
  logic clr, start, mem_ready;
  logic [DW-1:0] ir, bus_data;

  always #5 clk = ~clk;

  branch_sequencer_if #(.DATA_WIDTH(DW)) bi0 ();
  branch_sequencer_if #(.DATA_WIDTH(DW)) bi1 ();

  assign bi0.start = start;  assign bi0.mem_ready = mem_ready;
  assign bi0.ir = ir;        assign bi0.bus_data = bus_data;
  assign bi1.start = start;  assign bi1.mem_ready = mem_ready;
  assign bi1.ir = ir;        assign bi1.bus_data = bus_data;

  branch_sequencer #(.DATA_WIDTH(DW), .SKIP_NOT_TAKEN(1'b1)) dut0 (
    .clk(clk), .clr(clr), .bus(bi0.slave));
  branch_sequencer #(.DATA_WIDTH(DW), .SKIP_NOT_TAKEN(1'b0)) dut1 (
    .clk(clk), .clr(clr), .bus(bi1.slave));

  logic [1:0] busy_v, done_v, pcin_v, pcout_v, read_v, zlow_v, grb_v, con_v, ill_v, any_v;
  logic [4:0] alu_v [2];

  assign busy_v  = {bi1.busy, bi0.busy};
  assign done_v  = {bi1.done, bi0.done};
  assign pcin_v  = {bi1.pc_in, bi0.pc_in};
  assign pcout_v = {bi1.pc_out, bi0.pc_out};
  assign read_v  = {bi1.read, bi0.read};
  assign zlow_v  = {bi1.zlow_out, bi0.zlow_out};
  assign grb_v   = {bi1.grb, bi0.grb};
  assign con_v   = {bi1.con_ff, bi0.con_ff};
  assign ill_v   = {bi1.illegal, bi0.illegal};
  assign alu_v[0] = bi0.alu_op;
  assign alu_v[1] = bi1.alu_op;
  assign any_v[0] = |{bi0.pc_out, bi0.mar_in, bi0.inc_pc, bi0.z_in, bi0.zlow_out, bi0.pc_in,
                      bi0.read, bi0.mdr_in, bi0.mdr_out, bi0.ir_in, bi0.grb, bi0.rout,
                      bi0.y_in, bi0.c_out};
  assign any_v[1] = |{bi1.pc_out, bi1.mar_in, bi1.inc_pc, bi1.z_in, bi1.zlow_out, bi1.pc_in,
                      bi1.read, bi1.mdr_in, bi1.mdr_out, bi1.ir_in, bi1.grb, bi1.rout,
                      bi1.y_in, bi1.c_out};

  typedef struct {
    int vec; int lat; int con; int ill; int npc; int pcfirst;
    int nread; int nzlow; int ngrb; int nalu;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests_run = 0;
  int tests_failed = 0;
  int last_con = 0;

  int cyc[2], npc[2], pcf[2], nread[2], nzlow[2], ngrb[2], nalu[2];

  task automatic chk(input string name, input int d, input int vec, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s dut%0d vec%0d: got %0d expected %0d", name, d, vec, act, exp);
    end
  endtask

  task automatic clear_acc(input int d);
    cyc[d] = 0; npc[d] = 0; pcf[d] = 0; nread[d] = 0;
    nzlow[d] = 0; ngrb[d] = 0; nalu[d] = 0;
  endtask

  // Monitor: accumulates per-run observations and checks them against the scoreboard at done.
  initial begin
    exp_t e;
    bit have;
    for (int d = 0; d < 2; d++) clear_acc(d);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (clr) clear_acc(d);
        else if (busy_v[d]) begin
          cyc[d]++;
          if (pcin_v[d]) begin
            npc[d]++;
            if (pcf[d] == 0) pcf[d] = cyc[d];
          end
          if (read_v[d]) nread[d]++;
          if (zlow_v[d]) nzlow[d]++;
          if (grb_v[d]) ngrb[d]++;
          if (alu_v[d] == ADD) nalu[d]++;
          if (done_v[d]) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) chk("unexpected_done", d, -1, 1, 0);
            else begin
              chk("latency", d, e.vec, cyc[d], e.lat);
              chk("con_ff", d, e.vec, int'(con_v[d]), e.con);
              chk("illegal", d, e.vec, int'(ill_v[d]), e.ill);
              chk("pc_in_count", d, e.vec, npc[d], e.npc);
              chk("pc_in_first", d, e.vec, pcf[d], e.pcfirst);
              chk("read_count", d, e.vec, nread[d], e.nread);
              chk("zlow_count", d, e.vec, nzlow[d], e.nzlow);
              chk("grb_count", d, e.vec, ngrb[d], e.ngrb);
              chk("alu_add_count", d, e.vec, nalu[d], e.nalu);
            end
            clear_acc(d);
          end
        end else if (done_v[d]) chk("done_while_idle", d, -1, 1, 0);
      end
    end
  end

  task automatic push_exp(input int vec, input int waits, input bit taken, input bit illg);
    exp_t e;
    bit full;
    for (int d = 0; d < 2; d++) begin
      full      = !illg && (taken || d == 1);
      e.vec     = vec;
      e.lat     = 4 + waits + (full ? 4 : 1);
      e.con     = illg ? last_con : int'(taken);
      e.ill     = int'(illg);
      e.npc     = 1 + ((full && taken) ? 1 : 0);
      e.pcfirst = 2 + waits;
      e.nread   = 1 + waits;
      e.nzlow   = 1 + waits + (full ? 1 : 0);
      e.ngrb    = illg ? 0 : 1;
      e.nalu    = full ? 1 : 0;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (!illg) last_con = int'(taken);
  endtask

  task automatic run(input int vec, input logic [31:0] ir_v, input logic [31:0] bus_v,
                     input int waits, input bit taken, input bit illg);
    bit idle;
    push_exp(vec, waits, taken, illg);
    @(posedge clk); #1;
    ir = ir_v; bus_data = bus_v; mem_ready = (waits == 0); start = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++)
      chk("t0_entry", d, vec, int'(busy_v[d] && pcout_v[d]), 1);
    if (waits > 0) begin
      repeat (waits + 1) @(posedge clk);
      #1 mem_ready = 1'b1;
    end
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy_v == 2'b00) begin idle = 1'b1; break; end
    end
    chk("finish", 0, vec, int'(idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 1'b1; mem_ready = 1'b0; ir = '0; bus_data = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, 0, int'(busy_v[d]), 0);
      chk("rst_strobes", d, 0, int'(any_v[d]), 0);
      chk("rst_done", d, 0, int'(done_v[d]), 0);
      chk("rst_con", d, 0, int'(con_v[d]), 0);
      chk("rst_illegal", d, 0, int'(ill_v[d]), 0);
      chk("rst_alu", d, 0, int'(alu_v[d]), 0);
    end

    run(1, IR_MI, 32'hFFFF_FFF0, 0, 1'b1, 1'b0);
    run(2, IR_MI, 32'h0000_0003, 0, 1'b0, 1'b0);
    run(3, IR_ZR, 32'h0000_0000, 0, 1'b1, 1'b0);
    run(4, IR_NZ, 32'h0000_0000, 0, 1'b0, 1'b0);
    run(5, IR_PL, 32'h7FFF_FFFF, 0, 1'b1, 1'b0);
    run(6, IR_MI, 32'hFFFF_FFF0, 3, 1'b1, 1'b0);
    run(7, IR_BAD, 32'hFFFF_FFF0, 0, 1'b0, 1'b1);
    run(8, IR_NZ, 32'h0000_0005, 0, 1'b1, 1'b0);
    run(9, IR_PL, 32'h8000_0000, 0, 1'b0, 1'b0);

    // Abort mid-sequence from T4, then confirm a clean restart.
    @(posedge clk); #1;
    ir = IR_MI; bus_data = 32'hFFFF_FFF0; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("in_t4_pc_out", d, 10, int'(pcout_v[d]), 1);
      chk("in_t4_con", d, 10, int'(con_v[d]), 1);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("clr_busy", d, 10, int'(busy_v[d]), 0);
      chk("clr_con", d, 10, int'(con_v[d]), 0);
      chk("clr_strobes", d, 10, int'(any_v[d]), 0);
      chk("clr_done", d, 10, int'(done_v[d]), 0);
    end
    last_con = 0;
    run(11, IR_BAD, 32'h0000_0000, 0, 1'b0, 1'b1);
    run(12, IR_ZR, 32'h0000_0000, 2, 1'b1, 1'b0);
    run(13, IR_BAD, 32'h0000_0001, 0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    for (int d = 0; d < 2; d++)
      chk("scoreboard_empty", d, -1, (d == 0) ? q0.size() : q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, bus/IR width; minimum 8.
- BR_OPCODE, 5'b10010, branch opcode matched against ir[DATA_WIDTH-1:DATA_WIDTH-5].
- COND_LSB, 19, LSB of the 2-bit condition field in ir.
- SKIP_NOT_TAKEN, 1, 1 = abort to DONE after T3 when not taken; 0 = run T4-T6 with pc_in suppressed.
- ALU_ADD, 5'b00011, alu_op code for add.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- clr, in, 1, synchronous active-high reset.
- start, in, 1, begin fetch+branch sequence; sampled only in IDLE.
- mem_ready, in, 1, memory read data valid.
- ir, in, DATA_WIDTH, instruction register contents.
- bus_data, in, DATA_WIDTH, datapath bus value.
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, grb, rout, y_in, c_out, out, 1 each, datapath control strobes.
- alu_op, out, 5, ALU operation select.
- con_ff, out, 1, registered branch condition.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle completion pulse.
- illegal, out, 1, registered; set when fetched opcode != BR_OPCODE.

Function
REQ-003 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; each non-wait state lasts exactly one clock.
REQ-004 IDLE->T0 SHALL occur when start=1; start in any other state SHALL be ignored.
REQ-005 T0 SHALL assert pc_out, mar_in, inc_pc, z_in; next state T1.
REQ-006 T1 SHALL assert zlow_out, pc_in, read, mdr_in; remain in T1 while mem_ready=0; pc_in SHALL be asserted only in the cycle with mem_ready=1; next state T2.
REQ-007 T2 SHALL assert mdr_out, ir_in; next state T3.
REQ-008 In T3, if the opcode field != BR_OPCODE: set illegal, assert no strobes, go to DONE.
REQ-009 Otherwise T3 SHALL assert grb, rout and latch con_ff at the T3->next edge per c2 = ir[COND_LSB+1:COND_LSB]: 00 bus_data==0; 01 bus_data!=0; 10 bus_data[DATA_WIDTH-1]==0; 11 bus_data[DATA_WIDTH-1]==1.
REQ-010 After T3: if SKIP_NOT_TAKEN=1 and the condition evaluates 0, next state SHALL be DONE; else T4.
REQ-011 T4 SHALL assert pc_out, y_in; T5 SHALL assert c_out, z_in, alu_op=ALU_ADD; T6 SHALL assert zlow_out and assert pc_in only if con_ff=1; then DONE.
REQ-012 alu_op SHALL be 0 in all states except T5.
REQ-013 DONE SHALL assert done for one cycle and no strobes; next state IDLE unconditionally.
REQ-014 Strobes SHALL be decoded from the state register, con_ff and mem_ready only; no combinational path from ir or bus_data to any strobe.
REQ-015 con_ff and illegal SHALL hold their values from DONE until the next T3; illegal SHALL clear at T0.
REQ-016 Latency with mem_ready=1 at start->done: taken, or SKIP_NOT_TAKEN=0: 8 cycles (T0..DONE); not-taken with SKIP_NOT_TAKEN=1: 5 cycles; illegal: 5 cycles.

Reset
REQ-017 clr=1 at a rising edge SHALL force IDLE and clear con_ff, illegal, done and all strobes; alu_op=0; busy=0, including mid-sequence; clr SHALL take priority over start.
REQ-018 After clr deasserts, a start SHALL begin a normal sequence on the next edge.

Verification
REQ-019 clr held 2 cycles with start=1 -> all outputs 0, busy=0; first start after release enters T0.
REQ-020 ir=0x93180019 (brmi R6,25), bus_data=0xFFFFFFF0 in T3, mem_ready=1 -> con_ff=1; pc_in high in T1 and T6; done 8 cycles after start.
REQ-021 Same ir, bus_data=0x00000003, SKIP_NOT_TAKEN=1 -> con_ff=0; T4-T6 skipped; done 5 cycles after start; no pc_in after T1. With SKIP_NOT_TAKEN=0 -> done at 8 cycles; T6 has zlow_out=1 and pc_in=0.
REQ-022 c2=00 with bus_data=0 -> taken; c2=01 with bus_data=0 -> not taken; c2=10 with bus_data=0x7FFFFFFF -> taken.
REQ-023 mem_ready low for 3 cycles in T1 -> read and mdr_in high 4 cycles; pc_in high only in the final one; done at 11 cycles (taken).
REQ-024 clr asserted in T4 -> IDLE next edge, con_ff=0; opcode 5'b00000 fetched -> illegal=1, no grb/rout, done at 5 cycles.
